// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller between the MEM stage
// and a four-bank main memory; drives an external 256x4-word cache array.
module dcache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        c_en,
  output logic        c_comp,
  output logic        c_write,
  output logic        c_valid_in,
  output logic [7:0]  c_index,
  output logic [1:0]  c_word,
  output logic [4:0]  c_tag_in,
  output logic [15:0] c_data_in,
  input  logic        c_hit,
  input  logic        c_dirty,
  input  logic        c_valid,
  input  logic [4:0]  c_tag_out,
  input  logic [15:0] c_data_out,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_wr,
  output logic        m_rd,
  input  logic [15:0] m_data_out,
  input  logic        m_stall
);

  // Low two bits of the WB/RD/FL encodings give the word being handled.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RETRY = 4'd1,
    S_WB0   = 4'd4,
    S_WB1   = 4'd5,
    S_WB2   = 4'd6,
    S_WB3   = 4'd7,
    S_RD0   = 4'd8,
    S_RD1   = 4'd9,
    S_RD2   = 4'd10,
    S_RD3   = 4'd11,
    S_FL2   = 4'd14,
    S_FL3   = 4'd15
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] req_data_q, req_data_d;
  logic        req_wr_q, req_wr_d;
  logic [4:0]  victim_tag_q, victim_tag_d;

  logic        req_ok_s;
  logic        req_bad_s;
  logic        fill_en_s;
  logic [1:0]  fill_word_s;
  logic [1:0]  k_s;
  logic [4:0]  req_tag_s;
  logic [7:0]  req_index_s;

  assign req_ok_s    = (Rd ^ Wr) && !Addr[0];
  assign req_bad_s   = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
  assign k_s         = state_q[1:0];
  assign req_tag_s   = req_addr_q[15:11];
  assign req_index_s = req_addr_q[10:3];

  // Next-state and cache/memory/pipeline outputs; everything is zero during reset.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_wr_d     = req_wr_q;
    victim_tag_d = victim_tag_q;
    DataOut      = 16'h0000;
    Done         = 1'b0;
    Stall        = 1'b0;
    CacheHit     = 1'b0;
    err          = 1'b0;
    c_en         = 1'b0;
    c_comp       = 1'b0;
    c_write      = 1'b0;
    c_valid_in   = 1'b0;
    c_index      = 8'h00;
    c_word       = 2'b00;
    c_tag_in     = 5'h00;
    c_data_in    = 16'h0000;
    m_addr       = 16'h0000;
    m_data_in    = 16'h0000;
    m_wr         = 1'b0;
    m_rd         = 1'b0;
    fill_en_s    = 1'b0;
    fill_word_s  = 2'b00;

    if (rst) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_bad_s) begin
            err = 1'b1;
          end else if (req_ok_s) begin
            c_en      = 1'b1;
            c_comp    = 1'b1;
            c_write   = Wr;
            c_tag_in  = Addr[15:11];
            c_index   = Addr[10:3];
            c_word    = Addr[2:1];
            c_data_in = DataIn;
            if (c_hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              DataOut  = c_data_out;
            end else begin
              Stall        = 1'b1;
              req_addr_d   = Addr;
              req_data_d   = DataIn;
              req_wr_d     = Wr;
              victim_tag_d = c_tag_out;
              state_d      = (c_valid && c_dirty) ? S_WB0 : S_RD0;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WB0, S_WB1, S_WB2, S_WB3: begin
          Stall     = 1'b1;
          c_en      = 1'b1;
          c_index   = req_index_s;
          c_word    = k_s;
          m_wr      = 1'b1;
          m_addr    = {victim_tag_q, req_index_s, k_s, 1'b0};
          m_data_in = c_data_out;
          if (m_stall) begin
            state_d = state_q;
          end else if (state_q == S_WB3) begin
            state_d = S_RD0;
          end else begin
            state_d = state_t'(state_q + 4'd1);
          end
        end
        S_RD0, S_RD1, S_RD2, S_RD3: begin
          Stall  = 1'b1;
          m_rd   = 1'b1;
          m_addr = {req_tag_s, req_index_s, k_s, 1'b0};
          err    = m_stall;
          // Read data lags the request by two cycles, so RD2/RD3 store words 0/1.
          fill_en_s   = state_q[1];
          fill_word_s = k_s - 2'd2;
          if (state_q == S_RD3) begin
            state_d = S_FL2;
          end else begin
            state_d = state_t'(state_q + 4'd1);
          end
        end
        S_FL2, S_FL3: begin
          Stall       = 1'b1;
          fill_en_s   = 1'b1;
          fill_word_s = k_s;
          state_d     = (state_q == S_FL3) ? S_RETRY : S_FL3;
        end
        S_RETRY: begin
          Stall     = 1'b1;
          Done      = 1'b1;
          c_en      = 1'b1;
          c_comp    = 1'b1;
          c_write   = req_wr_q;
          c_tag_in  = req_tag_s;
          c_index   = req_index_s;
          c_word    = req_addr_q[2:1];
          c_data_in = req_data_q;
          DataOut   = c_data_out;
          state_d   = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (fill_en_s) begin
        c_en       = 1'b1;
        c_comp     = 1'b0;
        c_write    = 1'b1;
        c_valid_in = 1'b1;
        c_tag_in   = req_tag_s;
        c_index    = req_index_s;
        c_word     = fill_word_s;
        c_data_in  = m_data_out;
      end else begin
        fill_word_s = fill_word_s;
      end
    end
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_addr_q   <= 16'h0000;
      req_data_q   <= 16'h0000;
      req_wr_q     <= 1'b0;
      victim_tag_q <= 5'h00;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_wr_q     <= req_wr_d;
      victim_tag_q <= victim_tag_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Cycle-by-cycle vector bench for dcache_ctrl with behavioural cache-array and
// two-cycle-latency memory models.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn;
  logic        Rd, Wr;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;
  logic        c_en, c_comp, c_write, c_valid_in;
  logic [7:0]  c_index;
  logic [1:0]  c_word;
  logic [4:0]  c_tag_in;
  logic [15:0] c_data_in;
  logic        c_hit, c_dirty, c_valid;
  logic [4:0]  c_tag_out;
  logic [15:0] c_data_out;
  logic [15:0] m_addr, m_data_in;
  logic        m_wr, m_rd;
  logic [15:0] m_data_out;
  logic        m_stall;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .c_en(c_en), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_index(c_index), .c_word(c_word), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out), .m_addr(m_addr), .m_data_in(m_data_in), .m_wr(m_wr),
    .m_rd(m_rd), .m_data_out(m_data_out), .m_stall(m_stall)
  );

  // Cache array model
  bit          cv  [0:255];
  bit          cdt [0:255];
  logic [4:0]  ct  [0:255];
  logic [15:0] cd  [0:1023];

  assign c_valid    = cv[c_index];
  assign c_dirty    = cdt[c_index];
  assign c_tag_out  = ct[c_index];
  assign c_data_out = cd[{c_index, c_word}];
  assign c_hit      = c_en & c_comp & cv[c_index] & (ct[c_index] == c_tag_in);

  always @(posedge clk) begin
    if (c_en && c_write) begin
      if (c_comp) begin
        if (c_hit) begin
          cd[{c_index, c_word}] <= c_data_in;
          cdt[c_index]          <= 1'b1;
        end
      end else begin
        cd[{c_index, c_word}] <= c_data_in;
        ct[c_index]           <= c_tag_in;
        cv[c_index]           <= c_valid_in;
        cdt[c_index]          <= 1'b0;
      end
    end
  end

  // Memory model: unwritten word w reads as 16'h1000 + w
  bit          mw [0:32767];
  logic [15:0] md [0:32767];
  logic [15:0] p1, p2;

  function automatic logic [15:0] memrd(input logic [14:0] w);
    logic [15:0] base;
    base = 16'h1000 + {1'b0, w};
    return mw[w] ? md[w] : base;
  endfunction

  assign m_data_out = p2;

  always @(posedge clk) begin
    p1 <= (m_rd && !m_stall) ? memrd(m_addr[15:1]) : 16'hDEAD;
    p2 <= p1;
    if (m_wr && !m_stall) begin
      md[m_addr[15:1]] <= m_data_in;
      mw[m_addr[15:1]] <= 1'b1;
    end
  end

  // flags = {Done, Stall, CacheHit, err, c_en, m_rd, m_wr}
  localparam logic [6:0] F_IDLE  = 7'b0000000;
  localparam logic [6:0] F_MISS  = 7'b0100100;
  localparam logic [6:0] F_HIT   = 7'b1010100;
  localparam logic [6:0] F_RDA   = 7'b0100010;
  localparam logic [6:0] F_RDB   = 7'b0100110;
  localparam logic [6:0] F_RDE   = 7'b0101010;
  localparam logic [6:0] F_FL    = 7'b0100100;
  localparam logic [6:0] F_RETRY = 7'b1100100;
  localparam logic [6:0] F_WB    = 7'b0100101;
  localparam logic [6:0] F_ERR   = 7'b0001000;

  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] addr, din;
    logic        ms;
    logic [6:0]  flags;
    logic [15:0] maddr, dout;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] d, input logic ms,
                              input logic [6:0] f, input logic [15:0] ma, input logic [15:0] dout);
    vec_t v;
    v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.din = d; v.ms = ms;
    v.flags = f; v.maddr = ma; v.dout = dout;
    return v;
  endfunction

  task automatic mem_check(input logic [14:0] w, input logic [15:0] exp);
    logic [15:0] got;
    got = memrd(w);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL mem_word_%0h: got %h, expected %h", w, got, exp);
    end
  endtask

  initial begin
    logic [6:0] got_f;

    // cold-cache clean miss on 0x0000
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, F_IDLE, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, F_MISS, 16'h0000, 16'h0000));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, (k < 2) ? F_RDA : F_RDB, 16'(2 * k), 16'h0000));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, F_FL, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, F_RETRY, 16'h0000, 16'h1000));
    // store hit then load hit
    vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0002, 16'hBEEF, 1'b0, F_HIT, 16'h0000, 16'h1001));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_HIT, 16'h0000, 16'hBEEF));
    // dirty miss on 0x0802
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, F_MISS, 16'h0000, 16'h0000));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, F_WB, 16'(2 * k), 16'h0000));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, (k < 2) ? F_RDA : F_RDB, 16'h0800 + 16'(2 * k), 16'h0000));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, F_FL, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0802, 16'h0000, 1'b0, F_RETRY, 16'h0000, 16'h1401));
    // dirty line again, then miss with two m_stall cycles in WB1
    vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0800, 16'h1234, 1'b0, F_HIT, 16'h0000, 16'h1400));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_MISS, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_WB, 16'h0800, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, F_WB, 16'h0802, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, F_WB, 16'h0802, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_WB, 16'h0802, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_WB, 16'h0804, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_WB, 16'h0806, 16'h0000));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, (k < 2) ? F_RDA : F_RDB, 16'(2 * k), 16'h0000));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_FL, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_RETRY, 16'h0000, 16'hBEEF));
    // illegal requests, then a hit proves the FSM stayed in IDLE
    vq.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0000, 16'h5555, 1'b0, F_ERR, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, F_ERR, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0003, 16'h7777, 1'b0, F_ERR, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0002, 16'h0000, 1'b0, F_IDLE, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, F_HIT, 16'h0000, 16'hBEEF));
    // reset in RD2 abandons the miss; the reissued load is a fresh miss
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_MISS, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_RDA, 16'h1000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_RDA, 16'h1002, 16'h0000));
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_IDLE, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, F_IDLE, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_MISS, 16'h0000, 16'h0000));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, (k < 2) ? F_RDA : F_RDB, 16'h1000 + 16'(2 * k), 16'h0000));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_FL, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, F_RETRY, 16'h0000, 16'h1800));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1006, 16'h0000, 1'b0, F_HIT, 16'h0000, 16'h1803));
    // m_stall during RD1 flags err but the fill still advances
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, F_MISS, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, F_RDA, 16'h2000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, F_RDE, 16'h2002, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, F_RDB, 16'h2004, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, F_RDB, 16'h2006, 16'h0000));
    for (int k = 0; k < 2; k++)
      vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, F_FL, 16'h0000, 16'h0000));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 16'h2000, 16'h0000, 1'b0, F_RETRY, 16'h0000, 16'h2000));

    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000; m_stall = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; Rd = vq[i].rd; Wr = vq[i].wr;
      Addr = vq[i].addr; DataIn = vq[i].din; m_stall = vq[i].ms;
      #2;
      got_f = {Done, Stall, CacheHit, err, c_en, m_rd, m_wr};
      n_vec++;
      if (got_f !== vq[i].flags || m_addr !== vq[i].maddr || DataOut !== vq[i].dout) begin
        n_bad++;
        $display("FAIL vec_%0d: got flags=%b m_addr=%h DataOut=%h, expected flags=%b m_addr=%h DataOut=%h",
                 i, got_f, m_addr, DataOut, vq[i].flags, vq[i].maddr, vq[i].dout);
      end
    end

    @(negedge clk);
    Rd = 1'b0; Wr = 1'b0; m_stall = 1'b0;
    @(negedge clk);
    mem_check(15'h0000, 16'h1000);
    mem_check(15'h0001, 16'hBEEF);
    mem_check(15'h0400, 16'h1234);
    mem_check(15'h0401, 16'h1401);
    mem_check(15'h0403, 16'h1403);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
